instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 173 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_loader
//  Purpose  : Assembles a serial byte stream into big-endian 32-bit words and
//             writes them into instruction memory while holding the core.
//             Optional macro LOADER_CHECKSUM_EN adds a trailing checksum byte
//             (two's complement of the modulo-256 byte sum) and an error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  length,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    // State entered once all words are written (or at once for a zero-length load)
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHECK;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [LEN_W-1:0]    r_left;     // words still to be written, including the current one
    logic [ADDR_W-1:0]   r_idx;      // write address; wraps silently on long loads
    logic [1:0]          r_bcnt;     // byte position inside the current word
    logic [31:0]         r_word;
    logic                w_start_ok;
    logic                w_len_zero;
    logic                w_last;
    logic                w_load_acc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          r_sum;
    logic                r_error;
    logic [7:0]          w_check;
`endif

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_len_zero = (length == '0);
    assign w_last     = (r_left == LEN_W'(1));
    assign w_load_acc = (r_state == S_LOAD) && byte_valid;

    assign imem_addr  = r_idx;
    assign imem_wdata = r_word;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        core_hold  = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_len_zero ? S_END : S_LOAD;
                end
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                core_hold  = 1'b1;
                if (byte_valid && (r_bcnt == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                imem_we   = 1'b1;
                core_hold = 1'b1;
                w_next    = w_last ? S_END : S_LOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                core_hold  = 1'b1;
                if (byte_valid) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next = w_len_zero ? S_END : S_LOAD;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Word assembly, counters and write address
    always_ff @(posedge clock) begin
        if (reset) begin
            r_left <= '0;
            r_idx  <= '0;
            r_bcnt <= 2'd0;
            r_word <= 32'd0;
        end else if (w_start_ok) begin
            r_left <= length;
            r_idx  <= '0;
            r_bcnt <= 2'd0;
            r_word <= 32'd0;
        end else if (w_load_acc) begin
            r_word <= {r_word[23:0], byte_in};
            r_bcnt <= r_bcnt + 2'd1;
        end else if (r_state == S_WRITE) begin
            r_left <= r_left - LEN_W'(1);
            if (!w_last) begin
                r_idx <= r_idx + ADDR_W'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // A correct checksum byte brings the running sum to zero
    assign w_check = r_sum + byte_in;

    // Running byte sum and sticky checksum error
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sum   <= 8'd0;
            r_error <= 1'b0;
        end else if (w_start_ok) begin
            r_sum   <= 8'd0;
            r_error <= 1'b0;
        end else if (w_load_acc) begin
            r_sum <= r_sum + byte_in;
        end else if ((r_state == S_CHECK) && byte_valid) begin
            r_error <= (w_check != 8'd0);
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_mem_loader
//  Purpose  : Table-driven bench for instr_mem_loader with a write scoreboard.
//             Instantiated with ADDR_W=2 so address wrap is reachable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  length;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;

    always #5 clock = ~clock;

    instr_mem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .length     (length),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        int               len;
        logic [5:0][31:0] words;
        int               stall;       // idle cycles inserted after the first byte
        bit               mid_start;   // pulse start during the third byte
        bit               bad_csum;
        int               exp_cycles;  // first byte offer to done, no checksum
    } vec_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    vec_t vecs[7];
    wr_t  sb[$];
    wr_t  mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %h, no write required", imem_addr, imem_wdata);
            end else begin
                mon_e = sb.pop_front();
                check("write_addr", 32'(imem_addr), 32'(mon_e.addr));
                check("write_data", imem_wdata, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one byte until accepted; t_acc is the cycle in which it was taken
    task automatic send_byte(input logic [7:0] b, output int t_acc);
        bit got;
        bit rdy;
        got        = 1'b0;
        t_acc      = cyc;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            rdy   = byte_ready;
            t_acc = cyc;
            tick();
            got   = rdy;
            start = 1'b0;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_accept_timeout: byte %h never accepted", b);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         t0;
        int         ta;
        logic [7:0] sum;
        logic [7:0] bt;
        logic [7:0] cs;
        logic [31:0] wd;
        t0     = -1;
        sum    = 8'd0;
        start  = 1'b1;
        length = LEN_W'(v.len);
        tick();
        start  = 1'b0;
        length = '0;
        check("hold_after_start", 32'(core_hold), 32'((v.len != 0) || CSUM));
        check("done_after_start", 32'(done), 32'((v.len == 0) && !CSUM));
        for (int w = 0; w < v.len; w++) begin
            wd = v.words[w];
            sb.push_back('{addr: ADDR_W'(w), data: wd});
            for (int b = 0; b < 4; b++) begin
                bt = wd[31-8*b -: 8];
                if (v.mid_start && w == 0 && b == 2) begin
                    start  = 1'b1;
                    length = LEN_W'(7);
                end
                send_byte(bt, ta);
                start  = 1'b0;
                length = '0;
                if (t0 < 0) t0 = ta;
                sum = sum + bt;
                if (w == 0 && b == 0 && v.stall > 0) begin
                    byte_valid = 1'b0;
                    for (int s = 0; s < v.stall; s++) begin
                        check("stall_ready", 32'(byte_ready), 32'd1);
                        check("stall_no_we", 32'(imem_we), 32'd0);
                        tick();
                    end
                end
            end
        end
        if (CSUM) begin
            cs = 8'd0 - sum;
            if (v.bad_csum) cs = cs - 8'd1;
            send_byte(cs, ta);
        end
        byte_valid = 1'b0;
        for (int i = 0; i < 40 && done !== 1'b1; i++) tick();
        check("done_final", 32'(done), 32'd1);
        if (v.len > 0)
            check("latency", 32'(cyc - t0), 32'(v.exp_cycles + int'(CSUM)));
        check("error_final", 32'(error), 32'(CSUM && v.bad_csum));
        check("hold_final", 32'(core_hold), 32'd0);
        check("ready_final", 32'(byte_ready), 32'd0);
        check("writes_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"},    32'(imem_we),    32'd0);
        check({tag, "_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_wdata"}, imem_wdata,      32'd0);
        check({tag, "_hold"},  32'(core_hold),  32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_error"}, 32'(error),      32'd0);
    endtask

    initial begin
        vec_t fresh;
        int   ta;

        vecs[0] = '{len: 2, words: {32'h0, 32'h0, 32'h0, 32'h0, 32'h8C090000, 32'h20080005},
                    stall: 0, mid_start: 0, bad_csum: 0, exp_cycles: 10};
        vecs[1] = '{len: 1, words: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                    stall: 3, mid_start: 0, bad_csum: 0, exp_cycles: 8};
        vecs[2] = '{len: 0, words: '0,
                    stall: 0, mid_start: 0, bad_csum: 0, exp_cycles: 0};
        vecs[3] = '{len: 3, words: {32'h0, 32'h0, 32'h0, 32'h99AABBCC, 32'h55667788, 32'h11223344},
                    stall: 0, mid_start: 1, bad_csum: 0, exp_cycles: 15};
        vecs[4] = '{len: 5, words: {32'h0, 32'h13579BDF, 32'h00000000, 32'hFFFFFFFF, 32'hA5A55A5A, 32'h01020304},
                    stall: 0, mid_start: 0, bad_csum: 0, exp_cycles: 25};
        vecs[5] = '{len: 1, words: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h01020304},
                    stall: 0, mid_start: 0, bad_csum: 0, exp_cycles: 5};
        vecs[6] = '{len: 1, words: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h01020304},
                    stall: 0, mid_start: 0, bad_csum: 1, exp_cycles: 5};

        reset      = 1'b1;
        start      = 1'b0;
        length     = '0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset after six bytes of a three-word load: only word 0 may be written
        start  = 1'b1;
        length = LEN_W'(3);
        tick();
        start  = 1'b0;
        sb.push_back('{addr: ADDR_W'(0), data: 32'hA1B2C3D4});
        send_byte(8'hA1, ta);
        send_byte(8'hB2, ta);
        send_byte(8'hC3, ta);
        send_byte(8'hD4, ta);
        send_byte(8'hE5, ta);
        send_byte(8'hF6, ta);
        byte_valid = 1'b0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        check("midload_writes", 32'(sb.size()), 32'd0);
        check_all_zero("midload");
        for (int i = 0; i < 8; i++) tick();
        fresh = '{len: 1, words: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D},
                  stall: 0, mid_start: 0, bad_csum: 0, exp_cycles: 5};
        run_vec(fresh);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
